// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: write ports A/B, issue, packed read ports and
// the debug read port. Decode/writeback drive the master side, the register
// file is the slave.
interface regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                             ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]            ctrl_writeReg;
  logic [DATA_WIDTH-1:0]            data_writeReg;
  logic                             ctrl_writeEnableB;
  logic [ADDR_WIDTH-1:0]            ctrl_writeRegB;
  logic [DATA_WIDTH-1:0]            data_writeRegB;
  logic                             ctrl_issueEnable;
  logic [ADDR_WIDTH-1:0]            ctrl_issueReg;
  logic [NUM_READ*ADDR_WIDTH-1:0]   ctrl_readReg;
  logic [NUM_READ*DATA_WIDTH-1:0]   data_readReg;
  logic [NUM_READ-1:0]              busy_readReg;
  logic [ADDR_WIDTH-1:0]            ctrl_dbgReg;
  logic [DATA_WIDTH-1:0]            data_dbgReg;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_writeEnableB, ctrl_writeRegB, data_writeRegB,
    output ctrl_issueEnable, ctrl_issueReg,
    output ctrl_readReg, ctrl_dbgReg,
    input  data_readReg, busy_readReg, data_dbgReg
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_writeEnableB, ctrl_writeRegB, data_writeRegB,
    input  ctrl_issueEnable, ctrl_issueReg,
    input  ctrl_readReg, ctrl_dbgReg,
    output data_readReg, busy_readReg, data_dbgReg
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two prioritised write ports (A beats B on the
// same index), optional same-cycle write forwarding to the read ports, a
// per-register pending-write scoreboard and an unforwarded debug read port.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic            clock,
  input  logic            ctrl_reset,
  regfile_param_if.slave  rf_bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  logic w_weA;
  logic w_weB;
  logic w_issue;

  // Effective enables: index 0 is untouchable when hardwired, and B drops out
  // whenever A (even a suppressed A) claims the same index.
  always_comb begin
    w_weA   = rf_bus.ctrl_writeEnable &&
              !((ZERO_REG != 0) && (rf_bus.ctrl_writeReg == '0));
    w_weB   = rf_bus.ctrl_writeEnableB &&
              !((ZERO_REG != 0) && (rf_bus.ctrl_writeRegB == '0)) &&
              !(rf_bus.ctrl_writeEnable &&
                (rf_bus.ctrl_writeRegB == rf_bus.ctrl_writeReg));
    w_issue = rf_bus.ctrl_issueEnable &&
              !((ZERO_REG != 0) && (rf_bus.ctrl_issueReg == '0));
  end

  // Storage and scoreboard update; an issue is applied after the write clears
  // so a same-edge issue/write leaves the register pending.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_weB) r_mem[rf_bus.ctrl_writeRegB] <= rf_bus.data_writeRegB;
      if (w_weA) r_mem[rf_bus.ctrl_writeReg]  <= rf_bus.data_writeReg;
      if (w_weB) r_busy[rf_bus.ctrl_writeRegB] <= 1'b0;
      if (w_weA) r_busy[rf_bus.ctrl_writeReg]  <= 1'b0;
      if (w_issue) r_busy[rf_bus.ctrl_issueReg] <= 1'b1;
    end
  end

  genvar k;
  for (k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_busy;

    assign w_idx = rf_bus.ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Read port k: forwarded write data (A first) or stored value; outputs
    // are forced to zero while reset is held.
    always_comb begin
      w_data = r_mem[w_idx];
      w_busy = r_busy[w_idx];
      if (BYPASS != 0) begin
        if (w_weA && (w_idx == rf_bus.ctrl_writeReg)) begin
          w_data = rf_bus.data_writeReg;
          w_busy = 1'b0;
        end else if (w_weB && (w_idx == rf_bus.ctrl_writeRegB)) begin
          w_data = rf_bus.data_writeRegB;
          w_busy = 1'b0;
        end
      end
      if (ctrl_reset) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign rf_bus.data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign rf_bus.busy_readReg[k]                          = w_busy;
  end

  // Debug port shows only what is stored, never in-flight write data.
  always_comb begin
    rf_bus.data_dbgReg = ctrl_reset ? '0 : r_mem[rf_bus.ctrl_dbgReg];
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build (forwarding on), a
// non-forwarding build and a narrow 4-read-port build.
module tb_regfile_param;

  logic clock;
  logic ctrl_reset;

  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if0 ();
  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if1 ();
  regfile_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4)) if2 ();

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1))
    u_b1 (.clock(clock), .ctrl_reset(ctrl_reset), .rf_bus(if0));
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0), .ZERO_REG(1))
    u_b0 (.clock(clock), .ctrl_reset(ctrl_reset), .rf_bus(if1));
  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .BYPASS(1), .ZERO_REG(1))
    u_sw (.clock(clock), .ctrl_reset(ctrl_reset), .rf_bus(if2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        weB; logic [4:0] wb; logic [31:0] wdB;
    logic        ie;  logic [4:0] ir;
    logic [4:0]  r0;  logic [4:0] r1; logic [4:0] dbg;
    logic [31:0] e0;  logic [31:0] e1; logic [31:0] edbg;
    logic        eb0; logic eb1;
  } vec_t;

  function automatic vec_t mk(
    logic we, logic [4:0] wa, logic [31:0] wd,
    logic weB, logic [4:0] wb, logic [31:0] wdB,
    logic ie, logic [4:0] ir,
    logic [4:0] r0, logic [4:0] r1, logic [4:0] dbg,
    logic [31:0] e0, logic [31:0] e1, logic [31:0] edbg,
    logic eb0, logic eb1);
    vec_t v;
    v.we = we;   v.wa = wa;  v.wd = wd;
    v.weB = weB; v.wb = wb;  v.wdB = wdB;
    v.ie = ie;   v.ir = ir;
    v.r0 = r0;   v.r1 = r1;  v.dbg = dbg;
    v.e0 = e0;   v.e1 = e1;  v.edbg = edbg;
    v.eb0 = eb0; v.eb1 = eb1;
    return v;
  endfunction

  vec_t tbl[16];

  task automatic idle_all();
    if0.ctrl_writeEnable = 0; if0.ctrl_writeReg = 0; if0.data_writeReg = 0;
    if0.ctrl_writeEnableB = 0; if0.ctrl_writeRegB = 0; if0.data_writeRegB = 0;
    if0.ctrl_issueEnable = 0; if0.ctrl_issueReg = 0; if0.ctrl_readReg = 0; if0.ctrl_dbgReg = 0;
    if1.ctrl_writeEnable = 0; if1.ctrl_writeReg = 0; if1.data_writeReg = 0;
    if1.ctrl_writeEnableB = 0; if1.ctrl_writeRegB = 0; if1.data_writeRegB = 0;
    if1.ctrl_issueEnable = 0; if1.ctrl_issueReg = 0; if1.ctrl_readReg = 0; if1.ctrl_dbgReg = 0;
    if2.ctrl_writeEnable = 0; if2.ctrl_writeReg = 0; if2.data_writeReg = 0;
    if2.ctrl_writeEnableB = 0; if2.ctrl_writeRegB = 0; if2.data_writeRegB = 0;
    if2.ctrl_issueEnable = 0; if2.ctrl_issueReg = 0; if2.ctrl_readReg = 0; if2.ctrl_dbgReg = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //          we wa  wd            weB wb  wdB       ie ir   r0  r1  dbg  e0            e1            edbg          eb0 eb1
    tbl[0]  = mk(0, 0,  0,            0, 0,  0,        0, 0,   3,  5,  0,   0,            0,            0,            0, 0);
    tbl[1]  = mk(1, 3,  32'hDEADBEEF, 0, 0,  0,        0, 0,   3,  5,  3,   32'hDEADBEEF, 0,            0,            0, 0);
    tbl[2]  = mk(0, 0,  0,            0, 0,  0,        0, 0,   3,  3,  3,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[3]  = mk(1, 7,  32'h11,       1, 7,  32'h22,   0, 0,   7,  8,  0,   32'h11,       0,            0,            0, 0);
    tbl[4]  = mk(1, 8,  32'h33,       1, 9,  32'h44,   0, 0,   8,  9,  7,   32'h33,       32'h44,       32'h11,       0, 0);
    tbl[5]  = mk(0, 0,  0,            0, 0,  0,        0, 0,   7,  9,  8,   32'h11,       32'h44,       32'h33,       0, 0);
    tbl[6]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  32'h5A5A, 1, 0,   0,  0,  0,   0,            0,            0,            0, 0);
    tbl[7]  = mk(0, 0,  0,            0, 0,  0,        0, 0,   0,  3,  0,   0,            32'hDEADBEEF, 0,            0, 0);
    tbl[8]  = mk(0, 0,  0,            0, 0,  0,        1, 4,   4,  4,  4,   0,            0,            0,            0, 0);
    tbl[9]  = mk(0, 0,  0,            0, 0,  0,        0, 0,   4,  0,  4,   0,            0,            0,            1, 0);
    tbl[10] = mk(1, 4,  32'h55,       0, 0,  0,        0, 0,   4,  4,  4,   32'h55,       32'h55,       0,            0, 0);
    tbl[11] = mk(0, 0,  0,            0, 0,  0,        0, 0,   4,  4,  4,   32'h55,       32'h55,       32'h55,       0, 0);
    tbl[12] = mk(1, 4,  32'h66,       0, 0,  0,        1, 4,   4,  0,  4,   32'h66,       0,            32'h55,       0, 0);
    tbl[13] = mk(0, 0,  0,            0, 0,  0,        0, 0,   4,  4,  4,   32'h66,       32'h66,       32'h66,       1, 1);
    tbl[14] = mk(0, 0,  0,            1, 4,  32'h77,   0, 0,   9,  4,  4,   32'h44,       32'h77,       32'h66,       0, 0);
    tbl[15] = mk(0, 0,  0,            0, 0,  0,        0, 0,   4,  8,  4,   32'h77,       32'h33,       32'h77,       0, 0);

    idle_all();
    ctrl_reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    // Reset state, including a forwarded write that must stay invisible.
    if0.ctrl_writeEnable = 1; if0.ctrl_writeReg = 3; if0.data_writeReg = 32'hCAFE;
    if0.ctrl_issueEnable = 1; if0.ctrl_issueReg = 3;
    if0.ctrl_readReg = {5'd3, 5'd3}; if0.ctrl_dbgReg = 3;
    #2;
    chk("rst_rd", {32'd0, if0.data_readReg}, 64'd0);
    chk("rst_busy", {62'd0, if0.busy_readReg}, 64'd0);
    chk("rst_dbg", {32'd0, if0.data_dbgReg}, 64'd0);
    next_cycle();
    idle_all();
    if0.ctrl_readReg = {5'd3, 5'd3}; if0.ctrl_dbgReg = 3;
    ctrl_reset = 1'b0;
    #2;
    chk("rst_write_ignored", {32'd0, if0.data_readReg}, 64'd0);
    chk("rst_issue_ignored", {62'd0, if0.busy_readReg}, 64'd0);
    chk("rst_sweep_rd", {if2.data_readReg}, 64'd0);
    next_cycle();

    // Table-driven vectors on the forwarding build.
    for (int i = 0; i < 16; i++) begin
      if0.ctrl_writeEnable  = tbl[i].we;  if0.ctrl_writeReg  = tbl[i].wa; if0.data_writeReg  = tbl[i].wd;
      if0.ctrl_writeEnableB = tbl[i].weB; if0.ctrl_writeRegB = tbl[i].wb; if0.data_writeRegB = tbl[i].wdB;
      if0.ctrl_issueEnable  = tbl[i].ie;  if0.ctrl_issueReg  = tbl[i].ir;
      if0.ctrl_readReg      = {tbl[i].r1, tbl[i].r0};
      if0.ctrl_dbgReg       = tbl[i].dbg;
      #3;
      chk($sformatf("vec%0d_d0", i), {32'd0, if0.data_readReg[31:0]},  {32'd0, tbl[i].e0});
      chk($sformatf("vec%0d_d1", i), {32'd0, if0.data_readReg[63:32]}, {32'd0, tbl[i].e1});
      chk($sformatf("vec%0d_b0", i), {63'd0, if0.busy_readReg[0]}, {63'd0, tbl[i].eb0});
      chk($sformatf("vec%0d_b1", i), {63'd0, if0.busy_readReg[1]}, {63'd0, tbl[i].eb1});
      chk($sformatf("vec%0d_dbg", i), {32'd0, if0.data_dbgReg}, {32'd0, tbl[i].edbg});
      next_cycle();
    end
    idle_all();

    // Non-forwarding build: write shows up only after the edge; busy is the stored bit.
    if1.ctrl_writeEnable = 1; if1.ctrl_writeReg = 3; if1.data_writeReg = 32'hDEADBEEF;
    if1.ctrl_issueEnable = 1; if1.ctrl_issueReg = 2;
    if1.ctrl_readReg = {5'd2, 5'd3};
    #3;
    chk("nobyp_same_cycle", {32'd0, if1.data_readReg[31:0]}, 64'd0);
    next_cycle();
    if1.ctrl_writeEnable = 1; if1.ctrl_writeReg = 2; if1.data_writeReg = 32'h99;
    if1.ctrl_issueEnable = 0;
    #3;
    chk("nobyp_next_cycle", {32'd0, if1.data_readReg[31:0]}, 64'h0DEADBEEF);
    chk("nobyp_busy_in_write", {63'd0, if1.busy_readReg[1]}, 64'd1);
    chk("nobyp_data_in_write", {32'd0, if1.data_readReg[63:32]}, 64'd0);
    next_cycle();
    if1.ctrl_writeEnable = 0;
    #3;
    chk("nobyp_busy_cleared", {63'd0, if1.busy_readReg[1]}, 64'd0);
    chk("nobyp_data_after", {32'd0, if1.data_readReg[63:32]}, 64'h99);
    next_cycle();

    // Narrow build with four read ports.
    if2.ctrl_writeEnable = 1; if2.ctrl_writeReg = 1; if2.data_writeReg = 16'h0001;
    if2.ctrl_writeEnableB = 1; if2.ctrl_writeRegB = 2; if2.data_writeRegB = 16'h0002;
    next_cycle();
    if2.ctrl_writeReg = 3; if2.data_writeReg = 16'h0003;
    if2.ctrl_writeRegB = 4; if2.data_writeRegB = 16'h0004;
    next_cycle();
    if2.ctrl_writeEnable = 0; if2.ctrl_writeEnableB = 0;
    if2.ctrl_readReg = {3'd4, 3'd3, 3'd2, 3'd1};
    #3;
    for (int p = 0; p < 4; p++)
      chk($sformatf("sweep_port%0d", p), {48'd0, if2.data_readReg[16*p +: 16]}, 64'(p + 1));
    next_cycle();
    if2.ctrl_writeEnable = 1; if2.ctrl_writeReg = 2; if2.data_writeReg = 16'h00BB;
    if2.ctrl_dbgReg = 2;
    #3;
    chk("sweep_fwd_port1", {48'd0, if2.data_readReg[31:16]}, 64'h00BB);
    chk("sweep_dbg_stored", {48'd0, if2.data_dbgReg}, 64'h0002);
    next_cycle();
    if2.ctrl_writeEnable = 0;
    #3;
    chk("sweep_dbg_after", {48'd0, if2.data_dbgReg}, 64'h00BB);
    next_cycle();

    // Reset arriving mid-cycle while a write is pending.
    if0.ctrl_writeEnable = 1; if0.ctrl_writeReg = 5; if0.data_writeReg = 32'h1234;
    if0.ctrl_issueEnable = 1; if0.ctrl_issueReg = 6;
    next_cycle();
    idle_all();
    if0.ctrl_readReg = {5'd6, 5'd5}; if0.ctrl_dbgReg = 5;
    #2;
    chk("preload_r5", {32'd0, if0.data_readReg[31:0]}, 64'h1234);
    chk("preload_busy_r6", {63'd0, if0.busy_readReg[1]}, 64'd1);
    if0.ctrl_writeEnable = 1; if0.ctrl_writeReg = 5; if0.data_writeReg = 32'hAAAA;
    #1;
    chk("pre_rst_fwd", {32'd0, if0.data_readReg[31:0]}, 64'hAAAA);
    ctrl_reset = 1'b1;
    #1;
    chk("midrst_r5", {32'd0, if0.data_readReg[31:0]}, 64'd0);
    chk("midrst_busy", {62'd0, if0.busy_readReg}, 64'd0);
    chk("midrst_dbg", {32'd0, if0.data_dbgReg}, 64'd0);
    next_cycle();
    if0.ctrl_writeEnable = 0;
    #1;
    ctrl_reset = 1'b0;
    #1;
    chk("postrst_r5", {32'd0, if0.data_readReg[31:0]}, 64'd0);
    chk("postrst_busy_r6", {63'd0, if0.busy_readReg[1]}, 64'd0);
    chk("postrst_dbg_r5", {32'd0, if0.data_dbgReg}, 64'd0);
    if0.ctrl_readReg = {5'd4, 5'd3};
    #1;
    chk("postrst_r3", {32'd0, if0.data_readReg[31:0]}, 64'd0);
    chk("postrst_r4", {32'd0, if0.data_readReg[63:32]}, 64'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the CPU datapath, successor to the fixed 32x32 two-read/one-write file. Width, depth and read-port count are configurable. It has two write ports with fixed priority, optional write-to-read forwarding, a per-register pending-write scoreboard for hazard detection, and a debug read port for board-level display. It sits between decode (read/issue) and writeback (write/clear).

## Interface
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value
- ZERO_REG, 1, 1 = register 0 hardwired to 0

Ports:
- clock  in  1  rising-edge clock
- ctrl_reset  in  1  asynchronous, active-high reset
- ctrl_writeEnable  in  1  write port A enable
- ctrl_writeReg  in  ADDR_WIDTH  write port A index
- data_writeReg  in  DATA_WIDTH  write port A data
- ctrl_writeEnableB  in  1  write port B enable
- ctrl_writeRegB  in  ADDR_WIDTH  write port B index
- data_writeRegB  in  DATA_WIDTH  write port B data
- ctrl_issueEnable  in  1  mark ctrl_issueReg as pending-write
- ctrl_issueReg  in  ADDR_WIDTH  index being issued
- ctrl_readReg  in  NUM_READ*ADDR_WIDTH  packed read indices; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_readReg  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- busy_readReg  out  NUM_READ  pending-write flag per read port
- ctrl_dbgReg  in  ADDR_WIDTH  debug read index
- data_dbgReg  out  DATA_WIDTH  stored value of ctrl_dbgReg, never forwarded

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops plus one busy bit per register.
- Write: on posedge, each enabled port writes its data to its index.
- Write collision: if A and B are enabled with the same index, port A wins and B is dropped.
- Zero register (ZERO_REG=1): writes to index 0 are ignored. Issue to index 0 is ignored. Reads of index 0 return 0 with busy 0, even with BYPASS.
- Scoreboard:
  - posedge with ctrl_issueEnable sets busy[issueReg].
  - Any enabled write port clears busy[writeReg].
  - Issue and write to the same index in the same cycle: busy ends set, because a new producer is outstanding.
- Read data (combinational, per port k):
  - BYPASS=1 and an enabled write targets the read index: returns that write's data. Port A data is used if both ports target the index.
  - Otherwise returns the stored value.
  - No high-impedance outputs.
- Read busy (per port k):
  - BYPASS=1 and an enabled write targets the index: 0, regardless of same-cycle issue, because the issue takes effect next cycle.
  - Otherwise the stored busy bit.
- Debug port: always the stored value, no forwarding, no busy.

## Timing
- Reset (async assert, sync-safe deassert): all registers 0, all busy bits 0.
  - data_readReg and data_dbgReg read 0 and busy_readReg is 0 while reset is high.
  - Writes and issues are ignored while reset is high.
- Reset asserted mid-cycle with a write pending: the write is lost and the register is 0.
- Write latency: stored value visible 1 cycle after the write edge. With BYPASS=1 it is visible on read ports in the same cycle as the write inputs.
- Issue latency: busy visible on busy_readReg the cycle after the issue edge.
- Read and debug paths are purely combinational from index inputs to outputs.
- Out-of-range read indices cannot occur; depth is exactly 2**ADDR_WIDTH.

## Test plan
- Reset: preload r5=0x1234, assert ctrl_reset for 1 cycle between edges -> r5 reads 0 immediately, all busy 0, writes during reset have no effect.
- Write/read with BYPASS=1: write r3=0xDEADBEEF while port0 reads r3 -> port0 shows 0xDEADBEEF in the same cycle. With BYPASS=0 -> old value 0 in that cycle, 0xDEADBEEF next cycle.
- Dual-write collision: A writes r7=0x11, B writes r7=0x22 same edge -> r7=0x11. A writes r8=0x33, B writes r9=0x44 -> both stored.
- Zero register: write r0=0xFFFFFFFF and issue r0 -> r0 reads 0, busy 0 on every port and on debug.
- Scoreboard:
  - Issue r4 -> busy=1 next cycle.
  - Write r4=0x55 -> busy reads 0 in the write cycle (BYPASS=1) and stays 0 after.
  - Issue and write r4 same edge -> busy=1 afterward.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3, NUM_READ=4 -> each of 4 ports reads its own distinct register correctly (r1..r4 = 0x0001..0x0004). Debug port returns the stored value during a forwarded write.
